jt1943_romsched: RTL and testbench



---
 rtl/jt1943_romsched.sv | 190 +++++++++++++++++++
 tb/tb_jt1943_romsched.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt1943_romsched.sv
// jt1943_romsched
//   Read scheduler sitting between the per-chip ROM cache slots and the SDRAM
//   controller. One pending slot miss is picked, a single two-beat SDRAM read
//   is issued for it, the beats are packed into a 32-bit word, and the word is
//   handed back to the requesting slot with a cen-qualified write strobe.
//
// Parameters
//   SLOTS : number of request slots (2..8)
//   AW    : SDRAM word-address width; slot addresses use the same units
//
// Ports
//   i_clk         system clock
//   i_rst         synchronous, active-high reset
//   i_cen         slot-side clock enable; slots sample o_slot_we only on cen
//   i_slot_req    per-slot miss request (level)
//   i_slot_addr   packed slot addresses, slot i at [i*AW +: AW]
//   o_slot_we     one-hot refill strobe, held until a cen=1 cycle
//   o_slot_din    refill data, common to all slots
//   o_sdram_req   read request to the SDRAM controller (level)
//   o_sdram_addr  read address, bit 0 always 0
//   i_sdram_ack   one-cycle pulse: request accepted
//   i_sdram_dst   one-cycle pulse: i_sdram_data valid
//   i_sdram_data  read data beat
//
// Build option
//   JT1943_ROMSCHED_RR_EN : when defined, round-robin arbitration with a
//   pointer register; when undefined, fixed priority with slot 0 highest.
//
// State table
//   state      | meaning
//   S_IDLE     | arbitrate among pending slot requests
//   S_WAIT_ACK | SDRAM request held, waiting for acceptance
//   S_DATA     | collecting the two data beats
//   S_CHECK    | confirm the slot still wants this address
//   S_DELIVER  | refill strobe held until a cen cycle

module jt1943_romsched #(
  parameter int SLOTS = 4,
  parameter int AW    = 22
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cen,
  input  logic [SLOTS-1:0]      i_slot_req,
  input  logic [SLOTS*AW-1:0]   i_slot_addr,
  output logic [SLOTS-1:0]      o_slot_we,
  output logic [31:0]           o_slot_din,
  output logic                  o_sdram_req,
  output logic [AW-1:0]         o_sdram_addr,
  input  logic                  i_sdram_ack,
  input  logic                  i_sdram_dst,
  input  logic [15:0]           i_sdram_data
);

  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [AW-1:0] ADDR_MASK = ~AW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ACK,
    S_DATA,
    S_CHECK,
    S_DELIVER
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_sel;
  logic [AW-1:0]   r_addr;
  logic            r_beat;

  logic [SW-1:0]   w_win;
  logic            w_any;
  logic [AW-1:0]   w_win_addr;
  logic [AW-1:0]   w_sel_addr;
  logic            w_match;

`ifdef JT1943_ROMSCHED_RR_EN
  logic [SW-1:0]   r_ptr;

  function automatic logic [SW-1:0] f_wrap(input logic [SW-1:0] p, input int k);
    return SW'((int'(p) + k) % SLOTS);
  endfunction

  // Walk from the farthest offset down so the slot closest to the pointer wins.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int k = SLOTS-1; k >= 0; k--) begin
      if (i_slot_req[f_wrap(r_ptr, k)]) begin
        w_win = f_wrap(r_ptr, k);
        w_any = 1'b1;
      end
    end
  end
`else
  // Walk from the top down so the lowest requesting index wins.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int k = SLOTS-1; k >= 0; k--) begin
      if (i_slot_req[k]) begin
        w_win = SW'(k);
        w_any = 1'b1;
      end
    end
  end
`endif

  assign w_win_addr = i_slot_addr[int'(w_win)*AW +: AW] & ADDR_MASK;
  assign w_sel_addr = i_slot_addr[int'(r_sel)*AW +: AW] & ADDR_MASK;
  // Data is only useful if the slot is still missing on the same word.
  assign w_match    = i_slot_req[r_sel] && (w_sel_addr == r_addr);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_sel        <= '0;
      r_addr       <= '0;
      r_beat       <= 1'b0;
      o_sdram_req  <= 1'b0;
      o_sdram_addr <= '0;
      o_slot_we    <= '0;
      o_slot_din   <= '0;
`ifdef JT1943_ROMSCHED_RR_EN
      r_ptr        <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sel        <= w_win;
            r_addr       <= w_win_addr;
            o_sdram_req  <= 1'b1;
            o_sdram_addr <= w_win_addr;
            r_state      <= S_WAIT_ACK;
`ifdef JT1943_ROMSCHED_RR_EN
            // Advances on every issue, even if the data is later dropped.
            r_ptr        <= f_wrap(w_win, 1);
`endif
          end
        end

        S_WAIT_ACK: begin
          if (i_sdram_ack) begin
            o_sdram_req <= 1'b0;
            r_beat      <= 1'b0;
            r_state     <= S_DATA;
          end
        end

        S_DATA: begin
          if (i_sdram_dst) begin
            if (!r_beat) begin
              o_slot_din[15:0] <= i_sdram_data;
              r_beat           <= 1'b1;
            end else begin
              o_slot_din[31:16] <= i_sdram_data;
              r_beat            <= 1'b0;
              r_state           <= S_CHECK;
            end
          end
        end

        S_CHECK: begin
          if (w_match) begin
            o_slot_we <= SLOTS'(1) << r_sel;
            r_state   <= S_DELIVER;
          end else begin
            r_state   <= S_IDLE;
          end
        end

        S_DELIVER: begin
          // The slot samples the strobe on this same edge when cen is high.
          if (i_cen) begin
            o_slot_we <= '0;
            r_state   <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          o_sdram_req <= 1'b0;
          o_slot_we   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jt1943_romsched.sv
module tb_jt1943_romsched;

  logic        clk;
  logic        rst;
  logic        cen;
  logic [3:0]  slot_req;
  logic [87:0] slot_addr;
  logic [3:0]  slot_we;
  logic [31:0] slot_din;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        sdram_dst;
  logic [15:0] sdram_data;

  int n_cmp;
  int n_err;
  int cyc;
  int n_issue;
  logic gate;
  logic prev_req;

  jt1943_romsched #(.SLOTS(4), .AW(22)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cen        (cen),
    .i_slot_req   (slot_req),
    .i_slot_addr  (slot_addr),
    .o_slot_we    (slot_we),
    .o_slot_din   (slot_din),
    .o_sdram_req  (sdram_req),
    .o_sdram_addr (sdram_addr),
    .i_sdram_ack  (sdram_ack),
    .i_sdram_dst  (sdram_dst),
    .i_sdram_data (sdram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    cen = gate ? ((cyc % 4) == 0) : 1'b1;
    if (sdram_req && !prev_req) n_issue++;
    prev_req = sdram_req;
  endtask

  task automatic set_addr(input int s, input logic [21:0] a);
    slot_addr[s*22 +: 22] = a;
  endtask

  function automatic logic [21:0] slot_a(input int s);
    return 22'((s + 1) * 4096);
  endfunction

  task automatic wait_req(input string tag);
    int n = 0;
    while (!sdram_req && n < 64) begin
      tick();
      n++;
    end
    chk(tag, 64'(sdram_req), 64'h1);
  endtask

  task automatic wait_we(input string tag);
    int n = 0;
    while (slot_we == 4'b0 && n < 64) begin
      tick();
      n++;
    end
    chk(tag, 64'(slot_we != 4'b0), 64'h1);
  endtask

  task automatic serve(input int dly, input logic [15:0] b0, input logic [15:0] b1);
    repeat (dly) tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack  = 1'b0;
    sdram_dst  = 1'b1;
    sdram_data = b0;
    tick();
    sdram_data = b1;
    tick();
    sdram_dst  = 1'b0;
    sdram_data = 16'h0;
  endtask

  initial begin
    int   ord [6];
    int   prev;
    int   ncen;
    int   n;
    logic any_we;
    logic any_req;
    logic stable;

`ifdef JT1943_ROMSCHED_RR_EN
    ord = '{0, 1, 3, 0, 1, 3};
`else
    ord = '{0, 1, 0, 1, 0, 1};
`endif
    n_cmp = 0; n_err = 0; cyc = 0; n_issue = 0;
    gate = 1'b0; prev_req = 1'b0;
    rst = 1'b1; cen = 1'b1; slot_req = 4'b0; slot_addr = '0;
    sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_data = 16'h0;

    // reset values
    repeat (3) tick();
    chk("rst_we",    64'(slot_we),    64'h0);
    chk("rst_din",   64'(slot_din),   64'h0);
    chk("rst_req",   64'(sdram_req),  64'h0);
    chk("rst_addr",  64'(sdram_addr), 64'h0);
    rst = 1'b0;
    tick();
    chk("idle_req", 64'(sdram_req), 64'h0);

    // single miss, with a bogus dst coinciding with the ack
    set_addr(2, 22'h01235);
    slot_req = 4'b0100;
    tick();
    chk("single_req",  64'(sdram_req),  64'h1);
    chk("single_addr", 64'(sdram_addr), 64'h01234);
    sdram_ack = 1'b1; sdram_dst = 1'b1; sdram_data = 16'hFFFF;
    tick();
    chk("single_req_drop", 64'(sdram_req), 64'h0);
    sdram_ack = 1'b0; sdram_data = 16'hBEEF;
    tick();
    sdram_data = 16'hDEAD;
    tick();
    sdram_dst = 1'b0; sdram_data = 16'h0;
    tick();
    chk("single_we",  64'(slot_we),  64'h4);
    chk("single_din", 64'(slot_din), 64'hDEADBEEF);
    slot_req = 4'b0;
    tick();
    chk("single_we_clr", 64'(slot_we), 64'h0);
    repeat (3) tick();
    chk("single_no_reissue", 64'(sdram_req), 64'h0);

    // contention from a fresh reset so the rr pointer starts at 0
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    for (int s = 0; s < 4; s++) set_addr(s, slot_a(s));
    slot_req = 4'b1011;
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      wait_req("cont_issue");
      chk("cont_addr", 64'(sdram_addr), 64'(slot_a(ord[k])));
      if (prev >= 0) slot_req[prev] = 1'b1;
      serve(0, 16'(k), 16'(k + 16));
      wait_we("cont_we_seen");
      chk("cont_we", 64'(slot_we), 64'(4'(1 << ord[k])));
      slot_req[ord[k]] = 1'b0;
      prev = ord[k];
      tick();
    end
    slot_req = 4'b0;
    repeat (6) tick();

    // stale data: slot 1 moves on during the data phase
    set_addr(1, 22'h00100);
    slot_req = 4'b0010;
    wait_req("stale_issue");
    chk("stale_addr1", 64'(sdram_addr), 64'h00100);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0; sdram_dst = 1'b1; sdram_data = 16'h1234;
    tick();
    set_addr(1, 22'h00200);
    sdram_data = 16'h5678;
    tick();
    sdram_dst = 1'b0; sdram_data = 16'h0;
    any_we = 1'b0;
    repeat (2) begin
      any_we = any_we | (slot_we != 4'b0);
      tick();
    end
    chk("stale_no_we", 64'(any_we), 64'h0);
    wait_req("stale_reissue");
    chk("stale_addr2", 64'(sdram_addr), 64'h00200);
    serve(0, 16'h0202, 16'h2020);
    wait_we("stale_we_seen");
    chk("stale_we",  64'(slot_we),  64'h2);
    chk("stale_din", 64'(slot_din), 64'h20200202);
    slot_req = 4'b0;
    tick();
    repeat (3) tick();

    // cen one cycle in four
    gate = 1'b1;
    set_addr(0, 22'h00041);
    slot_req = 4'b0001;
    wait_req("cen_issue");
    chk("cen_addr", 64'(sdram_addr), 64'h00040);
    serve(0, 16'h1111, 16'h2222);
    wait_we("cen_we_seen");
    ncen = 0; n = 0;
    while (slot_we != 4'b0 && n < 16) begin
      chk("cen_we_held", 64'(slot_we), 64'h1);
      chk("cen_din", 64'(slot_din), 64'h22221111);
      if (cen) begin
        ncen++;
        slot_req = 4'b0;
      end
      tick();
      n++;
    end
    chk("cen_strobes", 64'(ncen), 64'h1);
    chk("cen_we_clr", 64'(slot_we), 64'h0);
    chk("cen_din_after", 64'(slot_din), 64'h22221111);
    gate = 1'b0;
    repeat (4) tick();

    // reset in the middle of the data phase
    set_addr(0, 22'h00300);
    slot_req = 4'b0001;
    wait_req("mid_issue");
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0; sdram_dst = 1'b1; sdram_data = 16'hAAAA;
    tick();
    sdram_dst = 1'b0;
    rst = 1'b1; slot_req = 4'b0;
    tick();
    chk("mid_rst_req", 64'(sdram_req), 64'h0);
    chk("mid_rst_we",  64'(slot_we),   64'h0);
    rst = 1'b0; sdram_dst = 1'b1; sdram_data = 16'h5555;
    tick();
    sdram_dst = 1'b0; sdram_data = 16'h0;
    any_we = 1'b0; any_req = 1'b0;
    repeat (8) begin
      any_we  = any_we | (slot_we != 4'b0);
      any_req = any_req | sdram_req;
      tick();
    end
    chk("mid_no_we",  64'(any_we),   64'h0);
    chk("mid_no_req", 64'(any_req),  64'h0);
    chk("mid_din",    64'(slot_din), 64'h0);

    // slow ack
    n_issue = 0;
    set_addr(3, 22'h3ABCD);
    slot_req = 4'b1000;
    wait_req("slow_issue");
    chk("slow_addr", 64'(sdram_addr), 64'h3ABCC);
    stable = 1'b1;
    repeat (20) begin
      tick();
      if (!sdram_req || sdram_addr !== 22'h3ABCC) stable = 1'b0;
    end
    chk("slow_stable", 64'(stable), 64'h1);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    chk("slow_req_drop", 64'(sdram_req), 64'h0);
    sdram_dst = 1'b1; sdram_data = 16'h0D0D;
    tick();
    sdram_dst = 1'b0;
    repeat (3) tick();
    sdram_dst = 1'b1; sdram_data = 16'hF0F0;
    tick();
    sdram_dst = 1'b0; sdram_data = 16'h0;
    wait_we("slow_we_seen");
    chk("slow_we",  64'(slot_we),  64'h8);
    chk("slow_din", 64'(slot_din), 64'hF0F00D0D);
    slot_req = 4'b0;
    tick();
    repeat (4) tick();
    chk("slow_one_issue", 64'(n_issue), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
